// File: rtl/mmio_uart_tx_if.sv
// Data-store bus slice seen by the memory-mapped UART transmitter.
// The core side drives the store strobe/address/data; the peripheral returns its read word and hit flag.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] RdData;
  logic        Hit;

  modport master (output MemWrite, DataAdr, WriteData, input RdData, Hit);
  modport slave  (input MemWrite, DataAdr, WriteData, output RdData, Hit);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA fill a small FIFO that a
// bit-timing FSM drains onto the tx pin; STATUS exposes overflow/busy/full/empty.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          overflow;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud_cnt;

  logic empty, full, sel_data, sel_status, sel_rsvd;
  logic push, pop, baud_done;
  logic unused_bits;

  assign sel_data   = (bus.DataAdr == BASE_ADDR);
  assign sel_status = (bus.DataAdr == BASE_ADDR + 32'd4);
  assign sel_rsvd   = (bus.DataAdr == BASE_ADDR + 32'd8);
  assign empty      = (count == '0);
  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  // full is taken before this edge's pop, so a store into a full FIFO is always dropped
  assign push       = bus.MemWrite && sel_data && !full;
  assign pop        = (state == IDLE) && !empty;
  assign baud_done  = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  assign bus.Hit    = sel_data || sel_status || sel_rsvd;
  assign bus.RdData = sel_status ? {28'b0, overflow, busy, full, empty} : 32'b0;
  assign unused_bits = ^bus.WriteData[31:8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.MemWrite && sel_data && full)
        overflow <= 1'b1;
      else if (bus.MemWrite && sel_status && bus.WriteData[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!empty) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-schedule model predicts tx/busy/STATUS each cycle
// from the byte queue and the edge at which each frame started.
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx, busy;
  int checks = 0;
  int failures = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: queue of buffered bytes plus the edge number at which the current frame began
  int         cyc = 0;
  logic [7:0] m_q[$];
  bit         m_frame = 0;
  int         m_p = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovf = 0;
  bit         m_idle, m_was_full;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_q.delete();
      m_frame = 0;
      m_ovf = 0;
    end else begin
      m_idle = !m_frame || (cyc > m_p + 10*CPB);
      m_was_full = (m_q.size() == DEPTH);
      if (m_idle && m_q.size() > 0) begin
        m_byte = m_q.pop_front();
        m_frame = 1;
        m_p = cyc;
      end
      if (bus.MemWrite && bus.DataAdr == BASE) begin
        if (m_was_full) m_ovf = 1;
        else m_q.push_back(bus.WriteData[7:0]);
      end
      if (bus.MemWrite && bus.DataAdr == BASE + 32'd4 && bus.WriteData[3]) m_ovf = 0;
    end
  end

  function automatic logic m_busy_f();
    return m_frame && (cyc - m_p < 10*CPB);
  endfunction

  function automatic logic m_tx_f();
    int o;
    if (!m_busy_f()) return 1'b1;
    o = (cyc - m_p) / CPB;
    if (o == 0) return 1'b0;
    if (o == 9) return 1'b1;
    return m_byte[o-1];
  endfunction

  function automatic logic [31:0] m_status_f();
    return {28'b0, m_ovf, m_busy_f(), m_q.size() == DEPTH, m_q.size() == 0};
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite = 1'b1;
    bus.DataAdr = addr;
    bus.WriteData = data;
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    reset = 1'b1;
    bus.DataAdr = BASE + 32'd4;
    #1;
    checks++;
    if (bus.RdData !== 32'h1 || bus.Hit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_status rd=%h hit=%b expected rd=00000001 hit=1", bus.RdData, bus.Hit);
    end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    bus_write(BASE, 32'h55);
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_prepop tx=%b expected 1", tx);
    end
    for (int i = 0; i < 10*CPB + 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== m_tx_f() || busy !== m_busy_f()) begin
        failures++;
        $display("[TB] FAIL single_frame cyc=%0d tx=%b busy=%b expected tx=%b busy=%b", cyc, tx, busy, m_tx_f(), m_busy_f());
      end
    end
  endtask

  task automatic test_back_to_back();
    bus_write(BASE, 32'hA3);
    bus_write(BASE, 32'h0F);
    for (int i = 0; i < 20*CPB + 6; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== m_tx_f() || busy !== m_busy_f()) begin
        failures++;
        $display("[TB] FAIL b2b_frame cyc=%0d tx=%b busy=%b expected tx=%b busy=%b", cyc, tx, busy, m_tx_f(), m_busy_f());
      end
    end
    bus.DataAdr = BASE + 32'd4;
    #1;
    checks++;
    if (bus.RdData !== 32'h1 || bus.RdData !== m_status_f()) begin
      failures++;
      $display("[TB] FAIL b2b_status rd=%h expected 00000001", bus.RdData);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    for (int b = 0; b < 10; b++) bus_write(BASE, b);
    bus.DataAdr = BASE + 32'd4;
    #1;
    checks++;
    if (bus.RdData !== 32'hE || bus.RdData !== m_status_f()) begin
      failures++;
      $display("[TB] FAIL ovf_status rd=%h expected 0000000e", bus.RdData);
    end
    bus_write(BASE + 32'd4, 32'h8);
    bus.DataAdr = BASE + 32'd4;
    #1;
    checks++;
    if (bus.RdData !== 32'h6 || bus.RdData !== m_status_f()) begin
      failures++;
      $display("[TB] FAIL ovf_clear rd=%h expected 00000006", bus.RdData);
    end
    for (int i = 0; i < 9*(10*CPB + 1) + 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== m_tx_f() || busy !== m_busy_f()) begin
        failures++;
        $display("[TB] FAIL ovf_stream cyc=%0d tx=%b busy=%b expected tx=%b busy=%b", cyc, tx, busy, m_tx_f(), m_busy_f());
      end
    end
  endtask

  task automatic test_full_pop_collision();
    bit found = 0;
    for (int b = 0; b < DEPTH + 1; b++) bus_write(BASE, 32'hB0 + b);
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_frame && (cyc + 1 > m_p + 10*CPB)) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL collision_wait timeout expected pop edge within 100 cycles");
    end
    bus_write(BASE, 32'hEE);
    bus.DataAdr = BASE + 32'd4;
    #1;
    checks++;
    if (bus.RdData !== 32'hC || bus.RdData !== m_status_f()) begin
      failures++;
      $display("[TB] FAIL collision_status rd=%h expected 0000000c", bus.RdData);
    end
    bus_write(BASE + 32'd4, 32'h8);
    for (int i = 0; i < DEPTH*(10*CPB + 1) + 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== m_tx_f() || busy !== m_busy_f()) begin
        failures++;
        $display("[TB] FAIL collision_stream cyc=%0d tx=%b busy=%b expected tx=%b busy=%b", cyc, tx, busy, m_tx_f(), m_busy_f());
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    bus_write(BASE, 32'($urandom_range(0, 255)));
    for (int i = 0; i < 40 && !(m_frame && cyc - m_p == 4*CPB + 1); i++) @(negedge clk);
    checks++;
    if (tx !== m_tx_f() || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_bit3 tx=%b busy=%b expected tx=%b busy=1", tx, busy, m_tx_f());
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.DataAdr = BASE + 32'd4;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.RdData !== 32'h1) begin
      failures++;
      $display("[TB] FAIL midreset_after tx=%b busy=%b rd=%h expected tx=1 busy=0 rd=00000001", tx, busy, bus.RdData);
    end
    for (int i = 0; i < 12*CPB; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_quiet cyc=%0d tx=%b busy=%b expected tx=1 busy=0", cyc, tx, busy);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs [3];
    logic        hits [3];
    addrs = '{BASE + 32'd2, BASE + 32'd8, BASE + 32'd12};
    hits  = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      bus.DataAdr = addrs[k];
      #1;
      checks++;
      if (bus.Hit !== hits[k] || bus.RdData !== 32'h0) begin
        failures++;
        $display("[TB] FAIL decode_hit adr=%h hit=%b rd=%h expected hit=%b rd=0", addrs[k], bus.Hit, bus.RdData, hits[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) bus_write(addrs[k], $urandom);
    repeat (3) @(negedge clk);
    bus.DataAdr = BASE + 32'd4;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.RdData !== 32'h1) begin
      failures++;
      $display("[TB] FAIL decode_nopush tx=%b busy=%b rd=%h expected tx=1 busy=0 rd=00000001", tx, busy, bus.RdData);
    end
  endtask

  task automatic test_random();
    int          r;
    logic [31:0] a;
    logic        exp_hit;
    logic [31:0] exp_rd;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== m_tx_f() || busy !== m_busy_f()) begin
        failures++;
        $display("[TB] FAIL random_line cyc=%0d tx=%b busy=%b expected tx=%b busy=%b", cyc, tx, busy, m_tx_f(), m_busy_f());
      end
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: a = BASE;
        3, 6:    a = BASE + 32'd4;
        4:       a = BASE + 32'd8;
        5:       a = BASE + 32'd12;
        7:       a = BASE + 32'd2;
        default: a = $urandom;
      endcase
      bus.MemWrite = (r < 6);
      bus.DataAdr = a;
      bus.WriteData = $urandom;
      #1;
      exp_hit = (a == BASE) || (a == BASE + 32'd4) || (a == BASE + 32'd8);
      exp_rd = (a == BASE + 32'd4) ? m_status_f() : 32'h0;
      checks++;
      if (bus.Hit !== exp_hit || bus.RdData !== exp_rd) begin
        failures++;
        $display("[TB] FAIL random_read adr=%h hit=%b rd=%h expected hit=%b rd=%h", a, bus.Hit, bus.RdData, exp_hit, exp_rd);
      end
    end
    @(negedge clk);
    bus.MemWrite = 1'b0;
    for (int i = 0; i < (DEPTH + 1)*(10*CPB + 1) + 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== m_tx_f() || busy !== m_busy_f()) begin
        failures++;
        $display("[TB] FAIL random_drain cyc=%0d tx=%b busy=%b expected tx=%b busy=%b", cyc, tx, busy, m_tx_f(), m_busy_f());
      end
    end
  endtask

  initial begin
    bus.MemWrite = 1'b0;
    bus.DataAdr = '0;
    bus.WriteData = '0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_pop_collision();
    test_mid_frame_reset();
    test_decode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-store bus (MemWrite, DataAdr, WriteData), in parallel with dmem.
- Gives the single-cycle RV32I core a serial output channel.
- Buffers store data in a small FIFO and serialises it as 8N1 frames on one output pin.
- Exposes a readable status word that the top level muxes onto ReadData when the address hits.

Parameters:
BASE_ADDR, 32'h0000_0100, word-aligned base of the 3-word register window
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
FIFO_DEPTH, 8, TX FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  one clock; reset is synchronous and active-low (reset=0 at a rising edge resets)
MemWrite  input  1  store strobe from core
DataAdr  input  32  store/load address from core
WriteData  input  32  store data from core
RdData  output  32  combinational read data for this window, 0 when no hit
Hit  output  1  combinational; 1 when DataAdr is BASE_ADDR, +4 or +8
tx  output  1  serial line, idle high
busy  output  1  1 while a frame is in progress (state != IDLE)

Behaviour:
- Register map (full 32-bit compare; DataAdr[1:0] must be 00):
  - BASE+0 TXDATA: write pushes WriteData[7:0]; reads 0.
  - BASE+4 STATUS: read returns {28'b0, overflow, busy, full, empty}. Write with WriteData[3]=1 clears overflow; other bits are ignored.
  - BASE+8: reserved; reads 0, writes ignored.
- Reset (reset=0 at an edge):
  - FIFO emptied; state=IDLE; tx=1; busy=0; overflow=0; bit and baud counters=0.
  - Applies mid-frame: tx returns to 1 after that edge and the partial frame is abandoned.
- Push: MemWrite=1 and DataAdr==BASE+0 at an edge, with FIFO not full.
  - If FIFO is full: data dropped, overflow set (sticky).
  - full is sampled before any same-edge pop, so a write to a full FIFO is dropped even when a pop occurs on that edge.
- FIFO flags:
  - Circular, with wrap-around read/write pointers plus a count of width log2(FIFO_DEPTH)+1.
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - A simultaneous push and pop (not full) leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is not empty at an edge, pop the head into an 8-bit shift register, go to START, clear the baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, shifting right after each bit. Go to STOP after bit index 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames (one extra idle-high cycle).
- Latency:
  - A push accepted at edge E into an empty FIFO with FSM idle is popped at edge E+1; tx falls after E+1.
  - Frame length = 10*CLKS_PER_BIT cycles.
- Outputs:
  - tx and busy are registered, with no combinational path from bus inputs.
  - RdData and Hit are purely combinational from DataAdr and internal state.

Test Plan:
- CLKS_PER_BIT=4. After reset, store 0x55 to BASE+0 -> tx falls 2 edges later, then bits 0,1,0,1,0,1,0,1,0,1 each for 4 cycles (40 cycles total). busy=1 throughout, then tx=1 and busy=0.
- Store 0xA3 and 0x0F back-to-back -> frames serialise in order, LSB first (A3: 1,1,0,0,0,1,0,1). Exactly one idle-high cycle between the stop bit and the second start bit. STATUS reads empty=1 at the end.
- FIFO_DEPTH=8, FSM busy: store 10 bytes 0x00..0x09 rapidly -> 0x00 in flight, 0x01..0x08 buffered, 0x09 dropped. STATUS=0x0000_000E (overflow, busy, full). Write 0x8 to BASE+4 -> STATUS bit3 clears. Transmitted stream is 0x00..0x08.
- Full FIFO with a pop occurring on the same edge as a store -> the store is dropped and overflow sets; count decrements by 1.
- Mid-frame (during DATA bit 3), assert reset=0 for one edge -> tx=1 after that edge, busy=0, STATUS=0x0000_0001. No further frame appears.
- Address decode: store to BASE+2, BASE+8 and BASE+12 -> no push, Hit=0 for BASE+2 and BASE+12, Hit=1 and RdData=0 for BASE+8.
